serial_fifo_tx: RTL and testbench

UART-style serial transmitter that drains a byte FIFO through its dequeue-side handshake (EMPTY_N in, DEQ out, D_OUT data in).
- Sits between the host-to-device FIFO and the TXD pad in the serial physical device.
- Converts each dequeued word into an asynchronous frame: start bit, data LSB-first, stop bit(s).
- It is the reader end of the FIFO protocol: it never dequeues while the FIFO is empty and dequeues exactly once per frame.

---
 rtl/serial_pkg.sv | 15 +
 rtl/serial_baud_gen.sv | 33 +++
 rtl/serial_fifo_tx.sv | 142 ++++++++++++++
 tb/tb_serial_fifo_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial physical device: transmitter state encoding and
// default line settings also used by the matching receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned SERIAL_CLK_DIV   = 868;
  localparam int unsigned SERIAL_DATA_BITS = 8;

endpackage

// File: rtl/serial_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 and flags the last cycle of every serial bit.
module serial_baud_gen #(
  parameter int unsigned CLK_DIV = serial_pkg::SERIAL_CLK_DIV
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_fifo_tx.sv
// Asynchronous-frame transmitter that drains a byte FIFO: start bit, data LSB-first,
// stop bit(s), one dequeue per frame and no idle gap while the FIFO stays non-empty.
module serial_fifo_tx
  import serial_pkg::*;
#(
  parameter int unsigned CLK_DIV   = SERIAL_CLK_DIV,
  parameter int unsigned DATA_BITS = SERIAL_DATA_BITS,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EMPTY_N,
  input  logic [DATA_BITS-1:0] D_OUT,
  output logic                 DEQ,
  output logic                 TXD,
  output logic                 BUSY,
  output logic                 TX_DONE
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("serial_fifo_tx: CLK_DIV must be in 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("serial_fifo_tx: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("serial_fifo_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 txd_q, txd_d;
  logic                 busy_q;
  logic                 tick;
  logic                 restart;
  logic                 frame_end;
  logic                 frame_load;

  // The bit index doubles as the stop-bit counter while in STOP.
  assign frame_end  = (state_q == STOP) && (bit_idx_q == LAST_STOP) && tick;
  assign frame_load = (state_q == IDLE) || frame_end;
  assign DEQ        = RST_N && EMPTY_N && frame_load;
  assign TX_DONE    = frame_end;
  assign TXD        = txd_q;
  assign BUSY       = busy_q;

  // Hold the timer at zero while idle so a new frame always starts on a full bit period.
  assign restart = (state_q == IDLE) || DEQ;

  serial_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;

    case (state_q)
      IDLE: begin
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_DATA) begin
            state_d   = STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_idx_q == LAST_STOP) begin
            state_d = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (DEQ) begin
      state_d   = START;
      shift_d   = D_OUT;
      bit_idx_d = '0;
    end

    // The line level is registered from the next state so TXD never glitches.
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  empty_n_known: assert property (@(posedge CLK) disable iff (!RST_N)
    frame_load |-> !$isunknown(EMPTY_N))
    else $warning("serial_fifo_tx: EMPTY_N unknown at frame-load point");

  deq_needs_data: assert property (@(posedge CLK) disable iff (!RST_N)
    DEQ |-> EMPTY_N);

  single_deq: assert property (@(posedge CLK) disable iff (!RST_N)
    DEQ |=> !DEQ);

endmodule

// File: tb/tb_serial_fifo_tx.sv
// Self-checking bench: two transmitter configurations compared cycle by cycle against
// a queue model of the expected line waveform.
module tb_serial_fifo_tx;

  localparam int unsigned DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       empty_n0, empty_n1;
  logic [7:0] d_out0;
  logic [6:0] d_out1;
  logic       deq0, txd0, busy0, tx_done0;
  logic       deq1, txd1, busy1, tx_done1;

  int n_checks;
  int n_fail;

  // Expected TXD level for every remaining cycle of the frames in flight.
  bit q0[$];
  bit q1[$];

  serial_fifo_tx #(
    .CLK_DIV   (DIV),
    .DATA_BITS (8),
    .STOP_BITS (1)
  ) u_dut0 (
    .CLK     (clk),
    .RST_N   (rst_n),
    .EMPTY_N (empty_n0),
    .D_OUT   (d_out0),
    .DEQ     (deq0),
    .TXD     (txd0),
    .BUSY    (busy0),
    .TX_DONE (tx_done0)
  );

  serial_fifo_tx #(
    .CLK_DIV   (DIV),
    .DATA_BITS (7),
    .STOP_BITS (2)
  ) u_dut1 (
    .CLK     (clk),
    .RST_N   (rst_n),
    .EMPTY_N (empty_n1),
    .D_OUT   (d_out1),
    .DEQ     (deq1),
    .TXD     (txd1),
    .BUSY    (busy1),
    .TX_DONE (tx_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic push_bits(input int sel, input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  task automatic push_frame(input int sel, input logic [8:0] d, input int db, input int sb);
    push_bits(sel, 1'b0, DIV);
    for (int i = 0; i < db; i++) push_bits(sel, d[i], DIV);
    push_bits(sel, 1'b1, sb * DIV);
  endtask

  // A frame may load when no frame remains or the current cycle is its last one.
  task automatic step();
    bit e0, e1;
    @(negedge clk);
    e0 = rst_n && empty_n0 && (q0.size() <= 1);
    e1 = rst_n && empty_n1 && (q1.size() <= 1);
    check("deq0",  32'(deq0),     32'(e0));
    check("txd0",  32'(txd0),     32'(q0.size() != 0 ? q0[0] : 1'b1));
    check("busy0", 32'(busy0),    32'(q0.size() != 0));
    check("done0", 32'(tx_done0), 32'(q0.size() == 1));
    check("deq1",  32'(deq1),     32'(e1));
    check("txd1",  32'(txd1),     32'(q1.size() != 0 ? q1[0] : 1'b1));
    check("busy1", 32'(busy1),    32'(q1.size() != 0));
    check("done1", 32'(tx_done1), 32'(q1.size() == 1));
    @(posedge clk);
    if (q0.size() != 0) void'(q0.pop_front());
    if (q1.size() != 0) void'(q1.pop_front());
    if (e0) push_frame(0, {1'b0, d_out0}, 8, 1);
    if (e1) push_frame(1, {2'b00, d_out1}, 7, 2);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    empty_n0 = 1'b1;
    empty_n1 = 1'b1;
    d_out0   = 8'hA5;
    d_out1   = 7'h00;

    // DEQ stays low in reset even with data waiting.
    repeat (3) step();
    empty_n0 = 1'b0;
    empty_n1 = 1'b0;
    rst_n    = 1'b1;
    repeat (50) step();

    // Single frames: 0xA5 on the 8N1 unit, 0x55 on the 7-bit two-stop unit.
    d_out0   = 8'hA5;
    empty_n0 = 1'b1;
    d_out1   = 7'h55;
    empty_n1 = 1'b1;
    step();
    empty_n0 = 1'b0;
    empty_n1 = 1'b0;
    d_out0   = 8'h00;
    repeat (45) step();

    // Back-to-back 0x00 then 0xFF.
    d_out0   = 8'h00;
    empty_n0 = 1'b1;
    step();
    d_out0 = 8'hFF;
    repeat (40) step();
    empty_n0 = 1'b0;
    repeat (45) step();

    // Inputs disturbed mid-frame while 0x81 is on the line.
    d_out0   = 8'h81;
    empty_n0 = 1'b1;
    step();
    d_out0   = 8'h3C;
    empty_n0 = 1'b0;
    repeat (15) step();
    empty_n0 = 1'b1;
    repeat (10) step();
    empty_n0 = 1'b0;
    repeat (30) step();

    // Reset in the middle of data bit 3, then restart with data already waiting.
    d_out0   = 8'h5A;
    empty_n0 = 1'b1;
    step();
    repeat (18) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_txd0",  32'(txd0),  32'(1'b1));
    check("rst_busy0", 32'(busy0), 32'(1'b0));
    check("rst_deq0",  32'(deq0),  32'(1'b0));
    check("rst_txd1",  32'(txd1),  32'(1'b1));
    check("rst_busy1", 32'(busy1), 32'(1'b0));
    q0.delete();
    q1.delete();
    @(posedge clk);
    #3;
    d_out0 = 8'hC3;
    rst_n  = 1'b1;
    step();
    empty_n0 = 1'b0;
    repeat (45) step();

    // Random traffic on both units.
    repeat (800) begin
      empty_n0 = ($urandom_range(0, 3) != 0);
      empty_n1 = ($urandom_range(0, 3) == 0);
      d_out0   = 8'($urandom);
      d_out1   = 7'($urandom);
      step();
    end
    empty_n0 = 1'b0;
    empty_n1 = 1'b0;
    repeat (100) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
